// File: rtl/fp_pkg.sv
// Shared single-precision FP types and constants for the FP ALU blocks.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp_32b_t;

    // Rounding-mode encodings
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Canonical quiet NaN; its bit 22 is also the quieting bit for sNaN inputs
    localparam logic [31:0] FP_QNAN      = 32'h7FC0_0000;
    localparam logic [31:0] FP_QUIET_BIT = 32'h0040_0000;
    localparam logic [30:0] FP_MAX_MAG   = 31'h7F7F_FFFF;
    localparam logic [30:0] FP_INF_MAG   = 31'h7F80_0000;

    // Iterative multiplier FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MULT  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;

    typedef enum logic [1:0] {
        FPM_IDLE  = ST_IDLE,
        FPM_MULT  = ST_MULT,
        FPM_ROUND = ST_ROUND
    } fp_mul_state_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic qnan;
        logic snan;
        logic denorm;
    } fp_class_t;

endpackage

// File: rtl/floating_point_rounder.sv
// Shared mantissa rounder: applies the rounding mode to a 23-bit mantissa
// given guard/round/sticky, reporting carry-out when the mantissa wraps.
module floating_point_rounder
    import fp_pkg::*;
(
    input  logic        sign,
    input  logic [22:0] mant_in,
    input  logic        guard,
    input  logic        round_bit,
    input  logic        sticky,
    input  logic [2:0]  rounding_mode,
    output logic [22:0] mant_out,
    output logic        carry_out
);

    logic lost;
    logic round_up;

    // Decide whether to increment, then add with carry-out
    always_comb begin
        lost     = guard | round_bit | sticky;
        round_up = 1'b0;
        case (rounding_mode)
            RM_RNE:  round_up = guard & (round_bit | sticky | mant_in[0]);
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = sign & lost;
            RM_RUP:  round_up = ~sign & lost;
            RM_RMM:  round_up = guard;
            default: round_up = 1'b0;
        endcase
        {carry_out, mant_out} = {1'b0, mant_in} + {23'd0, round_up};
    end

endmodule

// File: rtl/fp_operand_classify.sv
// Combinational operand classifier: zero / inf / qNaN / sNaN / denormal.
module fp_operand_classify
    import fp_pkg::*;
(
    input  fp_32b_t   op,
    output fp_class_t cls
);

    logic exp_max;
    logic exp_zero;
    logic mant_zero;

    // Decode the exponent/mantissa corner encodings
    always_comb begin
        exp_max    = &op.exp;
        exp_zero   = ~|op.exp;
        mant_zero  = ~|op.mant;
        cls.zero   = exp_zero & mant_zero;
        cls.denorm = exp_zero & ~mant_zero;
        cls.inf    = exp_max & mant_zero;
        cls.qnan   = exp_max & op.mant[22];
        cls.snan   = exp_max & ~mant_zero & ~op.mant[22];
    end

endmodule

// File: rtl/fp_multiplication_iterative.sv
// Iterative IEEE-754 single-precision multiplier. One operand pair at a time;
// the 24x24 mantissa product is built MSB-first, BITS_PER_CYCLE multiplier
// bits per MULT cycle, then normalised and rounded in a single ROUND cycle.
// Denormal inputs flush to zero.
// Optional: define FP_MUL_EARLY_OUT_EN to leave MULT as soon as the remaining
// multiplier bits are all zero (data-dependent latency, identical results).
module fp_multiplication_iterative
    import fp_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_data_in,
    output logic        ready_in,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [2:0]  rounding_mode,
    output logic [31:0] out,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact,
    output logic        invalid_operation,
    output logic        valid_data_out
);

    localparam int B     = BITS_PER_CYCLE;
    localparam int ITERS = 24 / BITS_PER_CYCLE;

    fp_mul_state_t      state;
    fp_32b_t            op_a, op_b;
    fp_class_t          cls_a, cls_b;

    logic [23:0]        mant_a;
    logic [23:0]        mult_sh;
    logic [47:0]        acc;
    logic [4:0]         cnt;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [2:0]         rm_r;
    logic               spec_r;
    logic [31:0]        spec_out_r;
    logic               spec_inv_r;
    logic               spec_uf_r;

    assign op_a     = in1;
    assign op_b     = in2;
    assign ready_in = (state == FPM_IDLE);

    fp_operand_classify u_cls_a (.op(op_a), .cls(cls_a));
    fp_operand_classify u_cls_b (.op(op_b), .cls(cls_b));

    logic               a_zero, b_zero;
    logic               in_special;
    logic               in_denorm;
    logic               in_sign;
    logic signed [9:0]  in_exp;
    logic [31:0]        spec_out;
    logic               spec_inv;

    // Special-case detection and result selection on the live inputs
    always_comb begin
        a_zero     = cls_a.zero | cls_a.denorm;
        b_zero     = cls_b.zero | cls_b.denorm;
        in_sign    = op_a.sign ^ op_b.sign;
        in_denorm  = cls_a.denorm | cls_b.denorm;
        in_exp     = $signed({2'b00, op_a.exp}) + $signed({2'b00, op_b.exp}) - 10'sd127;
        in_special = cls_a.qnan | cls_a.snan | cls_a.inf | a_zero |
                     cls_b.qnan | cls_b.snan | cls_b.inf | b_zero;
        spec_out   = '0;
        spec_inv   = 1'b0;
        if (cls_a.qnan) begin
            spec_out = in1;
        end else if (cls_b.qnan) begin
            spec_out = in2;
        end else if (cls_a.snan) begin
            spec_out = in1 | FP_QUIET_BIT;
            spec_inv = 1'b1;
        end else if (cls_b.snan) begin
            spec_out = in2 | FP_QUIET_BIT;
            spec_inv = 1'b1;
        end else if ((a_zero & cls_b.inf) | (cls_a.inf & b_zero)) begin
            spec_out = FP_QNAN;
            spec_inv = 1'b1;
        end else if (cls_a.inf | cls_b.inf) begin
            spec_out = {in_sign, FP_INF_MAG};
        end else begin
            spec_out = (rounding_mode == RM_RDN) ? 32'h8000_0000 : {in_sign, 31'd0};
        end
    end

    logic [B-1:0]       digit;
    logic [23:0]        mult_next;
    logic [47:0]        acc_step;
    logic [47:0]        acc_next;
    logic               mult_last;
`ifdef FP_MUL_EARLY_OUT_EN
    logic [5:0]         early_shamt;
`endif

    // One shift-add step, MSB-first over the multiplier
    always_comb begin
        digit     = mult_sh[23 -: B];
        mult_next = mult_sh << B;
        acc_step  = (acc << B) + (48'(mant_a) * 48'(digit));
        acc_next  = acc_step;
        mult_last = (cnt == 5'(ITERS - 1));
`ifdef FP_MUL_EARLY_OUT_EN
        // Remaining digits are zero: align as if the skipped steps had run
        early_shamt = 6'((ITERS - 1 - int'(cnt)) * B);
        if (!mult_last && (mult_next == '0)) begin
            acc_next  = acc_step << early_shamt;
            mult_last = 1'b1;
        end
`endif
    end

    logic               hi;
    logic [22:0]        mant_pre;
    logic [22:0]        mant_rnd;
    logic               g, r, s;
    logic               rnd_carry;
    logic signed [9:0]  exp_n;
    logic signed [9:0]  exp_f;

    // Normalise the [1,4) product and pick guard/round/sticky
    always_comb begin
        hi = acc[47];
        if (hi) begin
            mant_pre = acc[46:24];
            g        = acc[23];
            r        = acc[22];
            s        = |acc[21:0];
        end else begin
            mant_pre = acc[45:23];
            g        = acc[22];
            r        = acc[21];
            s        = |acc[20:0];
        end
        exp_n = exp_r + $signed({9'd0, hi});
    end

    floating_point_rounder u_rnd (
        .sign          (sign_r),
        .mant_in       (mant_pre),
        .guard         (g),
        .round_bit     (r),
        .sticky        (s),
        .rounding_mode (rm_r),
        .mant_out      (mant_rnd),
        .carry_out     (rnd_carry)
    );

    logic [31:0]        res_out;
    logic               res_ov, res_uf, res_inx, res_inv;

    // Final result: special, overflow, underflow or normal
    always_comb begin
        exp_f   = exp_n + $signed({9'd0, rnd_carry});
        res_out = '0;
        res_ov  = 1'b0;
        res_uf  = 1'b0;
        res_inx = 1'b0;
        res_inv = 1'b0;
        if (spec_r) begin
            res_out = spec_out_r;
            res_uf  = spec_uf_r;
            res_inv = spec_inv_r;
        end else if (exp_f > 10'sd254) begin
            res_ov  = 1'b1;
            res_inx = 1'b1;
            case (rm_r)
                RM_RTZ:  res_out = {sign_r, FP_MAX_MAG};
                RM_RDN:  res_out = sign_r ? {1'b1, FP_INF_MAG} : {1'b0, FP_MAX_MAG};
                RM_RUP:  res_out = sign_r ? {1'b1, FP_MAX_MAG} : {1'b0, FP_INF_MAG};
                default: res_out = {sign_r, FP_INF_MAG};
            endcase
        end else if (exp_f <= 10'sd0) begin
            res_out = (rm_r == RM_RDN) ? 32'h8000_0000 : {sign_r, 31'd0};
            res_inx = 1'b1;
            res_uf  = g | r | s;
        end else begin
            res_out = {sign_r, exp_f[7:0], rnd_carry ? 23'd0 : mant_rnd};
            res_inx = g | r | s;
        end
    end

    // Control FSM and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FPM_IDLE;
            mant_a     <= '0;
            mult_sh    <= '0;
            acc        <= '0;
            cnt        <= '0;
            sign_r     <= 1'b0;
            exp_r      <= '0;
            rm_r       <= '0;
            spec_r     <= 1'b0;
            spec_out_r <= '0;
            spec_inv_r <= 1'b0;
            spec_uf_r  <= 1'b0;
        end else begin
            case (state)
                FPM_IDLE: begin
                    if (valid_data_in) begin
                        mant_a     <= {1'b1, op_a.mant};
                        mult_sh    <= {1'b1, op_b.mant};
                        acc        <= '0;
                        cnt        <= '0;
                        sign_r     <= in_sign;
                        exp_r      <= in_exp;
                        rm_r       <= rounding_mode;
                        spec_r     <= in_special;
                        spec_out_r <= spec_out;
                        spec_inv_r <= spec_inv;
                        spec_uf_r  <= in_denorm;
                        state      <= in_special ? FPM_ROUND : FPM_MULT;
                    end
                end
                FPM_MULT: begin
                    acc     <= acc_next;
                    mult_sh <= mult_next;
                    cnt     <= cnt + 5'd1;
                    if (mult_last) state <= FPM_ROUND;
                end
                FPM_ROUND: state <= FPM_IDLE;
                default:   state <= FPM_IDLE;
            endcase
        end
    end

    // Result registers: updated only in ROUND, held until the next result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out               <= '0;
            overflow          <= 1'b0;
            underflow         <= 1'b0;
            inexact           <= 1'b0;
            invalid_operation <= 1'b0;
            valid_data_out    <= 1'b0;
        end else begin
            valid_data_out <= (state == FPM_ROUND);
            if (state == FPM_ROUND) begin
                out               <= res_out;
                overflow          <= res_ov;
                underflow         <= res_uf;
                inexact           <= res_inx;
                invalid_operation <= res_inv;
            end
        end
    end

endmodule

// File: tb/tb_fp_multiplication_iterative.sv
// Directed bench for fp_multiplication_iterative (default BITS_PER_CYCLE=2).
module tb_fp_multiplication_iterative;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;

`ifdef FP_MUL_EARLY_OUT_EN
    localparam int LAT_3X25 = 3;
`else
    localparam int LAT_3X25 = 13;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_data_in;
    logic        ready_in;
    logic [31:0] in1, in2;
    logic [2:0]  rounding_mode;
    logic [31:0] out;
    logic        overflow, underflow, inexact, invalid_operation, valid_data_out;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;

    assign flags = {overflow, underflow, inexact, invalid_operation};

    always #5 clk = ~clk;

    fp_multiplication_iterative dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .valid_data_in     (valid_data_in),
        .ready_in          (ready_in),
        .in1               (in1),
        .in2               (in2),
        .rounding_mode     (rounding_mode),
        .out               (out),
        .overflow          (overflow),
        .underflow         (underflow),
        .inexact           (inexact),
        .invalid_operation (invalid_operation),
        .valid_data_out    (valid_data_out)
    );

    // Present one pair, accept at E0, return edges until the strobe (-1 on timeout)
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rm, output int lat);
        @(negedge clk);
        in1 = a; in2 = b; rounding_mode = rm; valid_data_in = 1'b1;
        @(posedge clk);
        #1 valid_data_in = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (valid_data_out) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL timeout: no valid_data_out for %h x %h", a, b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_data_in = 1'b0; in1 = '0; in2 = '0; rounding_mode = RNE;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want 0", out); end
        checks++; if (flags !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
        checks++; if (valid_data_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_data_out); end
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_in); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_normal();
        int lat;
        do_op(32'h4040_0000, 32'h4020_0000, RNE, lat);
        checks++; if (out !== 32'h40F0_0000) begin errors++; $display("FAIL mul_3x2p5: got %h want 40f00000", out); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL mul_3x2p5_flags: got %b want 0000", flags); end
        checks++; if (lat !== LAT_3X25) begin errors++; $display("FAIL mul_3x2p5_lat: got %0d want %0d", lat, LAT_3X25); end
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL ready_in_strobe: got %b want 1", ready_in); end
        @(posedge clk); #1;
        checks++; if (valid_data_out !== 1'b0) begin errors++; $display("FAIL strobe_width: got %b want 0", valid_data_out); end
        do_op(32'hC000_0000, 32'h4040_0000, RNE, lat);
        checks++; if (out !== 32'hC0C0_0000) begin errors++; $display("FAIL mul_neg2x3: got %h want c0c00000", out); end
    endtask

    task automatic test_rounding();
        int lat;
        do_op(32'h3F80_0001, 32'h3F80_0001, RNE, lat);
        checks++; if (out !== 32'h3F80_0002) begin errors++; $display("FAIL ulp_rne: got %h want 3f800002", out); end
        checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL ulp_rne_flags: got %b want 0010", flags); end
        checks++; if (lat !== 13) begin errors++; $display("FAIL ulp_rne_lat: got %0d want 13", lat); end
        do_op(32'h3F80_0001, 32'h3F80_0001, RTZ, lat);
        checks++; if (out !== 32'h3F80_0002) begin errors++; $display("FAIL ulp_rtz: got %h want 3f800002", out); end
        checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL ulp_rtz_flags: got %b want 0010", flags); end
    endtask

    task automatic test_overflow();
        int lat;
        do_op(32'h7F7F_FFFF, 32'h4000_0000, RNE, lat);
        checks++; if (out !== 32'h7F80_0000) begin errors++; $display("FAIL ovf_rne: got %h want 7f800000", out); end
        checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL ovf_rne_flags: got %b want 1010", flags); end
        do_op(32'h7F7F_FFFF, 32'h4000_0000, RTZ, lat);
        checks++; if (out !== 32'h7F7F_FFFF) begin errors++; $display("FAIL ovf_rtz: got %h want 7f7fffff", out); end
        checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL ovf_rtz_flags: got %b want 1010", flags); end
        do_op(32'hFF7F_FFFF, 32'h4000_0000, RUP, lat);
        checks++; if (out !== 32'hFF7F_FFFF) begin errors++; $display("FAIL ovf_rup_neg: got %h want ff7fffff", out); end
        do_op(32'h7F7F_FFFF, 32'h4000_0000, RDN, lat);
        checks++; if (out !== 32'h7F7F_FFFF) begin errors++; $display("FAIL ovf_rdn_pos: got %h want 7f7fffff", out); end
    endtask

    task automatic test_special();
        int lat;
        do_op(32'h0000_0000, 32'h7F80_0000, RNE, lat);
        checks++; if (out !== 32'h7FC0_0000) begin errors++; $display("FAIL zero_x_inf: got %h want 7fc00000", out); end
        checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL zero_x_inf_flags: got %b want 0001", flags); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL zero_x_inf_lat: got %0d want 1", lat); end
        do_op(32'h7F80_0001, 32'h3F80_0000, RNE, lat);
        checks++; if (out !== 32'h7FC0_0001) begin errors++; $display("FAIL snan_quiet: got %h want 7fc00001", out); end
        checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL snan_flags: got %b want 0001", flags); end
        do_op(32'h3F80_0000, 32'hFFC0_0005, RNE, lat);
        checks++; if (out !== 32'hFFC0_0005) begin errors++; $display("FAIL qnan_in2: got %h want ffc00005", out); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL qnan_in2_flags: got %b want 0000", flags); end
        do_op(32'h7F80_0000, 32'hC000_0000, RNE, lat);
        checks++; if (out !== 32'hFF80_0000) begin errors++; $display("FAIL inf_x_neg2: got %h want ff800000", out); end
    endtask

    task automatic test_underflow();
        int lat;
        do_op(32'h0000_0001, 32'h3F80_0000, RNE, lat);
        checks++; if (out !== 32'h0000_0000) begin errors++; $display("FAIL denorm_rne: got %h want 00000000", out); end
        checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL denorm_rne_flags: got %b want 0100", flags); end
        do_op(32'h0000_0001, 32'h3F80_0000, RDN, lat);
        checks++; if (out !== 32'h8000_0000) begin errors++; $display("FAIL denorm_rdn: got %h want 80000000", out); end
        checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL denorm_rdn_flags: got %b want 0100", flags); end
        do_op(32'h0080_0001, 32'h3F40_0000, RNE, lat);
        checks++; if (out !== 32'h0000_0000) begin errors++; $display("FAIL norm_underflow: got %h want 00000000", out); end
        checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL norm_underflow_flags: got %b want 0110", flags); end
    endtask

    task automatic test_back_to_back();
        int strobes = 0;
        int k1 = -1;
        @(negedge clk);
        in1 = 32'h4040_0000; in2 = 32'h4020_0000; rounding_mode = RNE; valid_data_in = 1'b1;
        @(posedge clk);
        #1 in1 = 32'h3F80_0001; in2 = 32'h3F80_0001;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (k1 > 0 && k == k1 + 1) begin
                checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL b2b_accept: ready_in got %b want 0", ready_in); end
                valid_data_in = 1'b0;
            end
            if (valid_data_out) begin
                strobes++;
                if (strobes == 1) begin
                    k1 = k;
                    checks++; if (out !== 32'h40F0_0000) begin errors++; $display("FAIL b2b_first: got %h want 40f00000", out); end
                end else begin
                    checks++; if (out !== 32'h3F80_0002) begin errors++; $display("FAIL b2b_second: got %h want 3f800002", out); end
                end
            end
        end
        valid_data_in = 1'b0;
        checks++; if (strobes !== 2) begin errors++; $display("FAIL b2b_strobes: got %0d want 2", strobes); end
    endtask

    task automatic test_reset_mid_op();
        int strobes = 0;
        @(negedge clk);
        in1 = 32'h3F80_0001; in2 = 32'h3F80_0001; rounding_mode = RNE; valid_data_in = 1'b1;
        @(posedge clk);
        #1 valid_data_in = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out !== 32'h0) begin errors++; $display("FAIL midrst_out: got %h want 0", out); end
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", ready_in); end
        checks++; if (flags !== 4'b0) begin errors++; $display("FAIL midrst_flags: got %b want 0000", flags); end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 if (valid_data_out) strobes++;
        end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL midrst_strobe: got %0d want 0", strobes); end
    endtask

`ifdef FP_MUL_EARLY_OUT_EN
    task automatic test_early_out();
        int lat;
        do_op(32'h4040_0000, 32'h3F80_0000, RNE, lat);
        checks++; if (out !== 32'h4040_0000) begin errors++; $display("FAIL early_out: got %h want 40400000", out); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL early_out_lat: got %0d want 2", lat); end
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_rounding();
        test_overflow();
        test_special();
        test_underflow();
        test_back_to_back();
`ifdef FP_MUL_EARLY_OUT_EN
        test_early_out();
`endif
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
